// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default widths and pointer helpers
// used by both the write-side and read-side control logic.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int PTR_MAX_W      = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Output buffer action for one clock edge
  typedef enum logic [1:0] {
    BUF_IDLE,
    BUF_POP,
    BUF_PUSH,
    BUF_SWAP
  } buf_op_t;

  // Gray to binary; narrower pointers are zero-extended by the caller
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing
// into the local clock domain.
module ptr_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  // Two-stage resynchronization of the incoming pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side control: synchronized empty/level, read
// issue with credit, and a 2-entry skid buffer onto a ready/valid stream.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_B,
  input  logic                  rst_B,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_en,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         s2;
  logic [PW-1:0]         wr_bin_sync;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [1:0]            cnt;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            credit;
  buf_op_t               op;

  ptr_sync #(
    .W(PW)
  ) u_ptr_sync (
    .clk(clk_B),
    .rst(rst_B),
    .d  (wr_ptr_gray),
    .q  (s2)
  );

  assign wr_bin_sync = PW'(gray2bin(PTR_MAX_W'(s2)));

  assign empty    = (wr_bin_sync == rd_ptr);
  assign rd_level = wr_bin_sync - rd_ptr;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = head;
  assign pop     = m_valid & m_ready;

  // Words buffered plus in flight, after this cycle's pop
  assign credit = 3'(cnt) + 3'(inflight) - 3'(pop);
  assign rd_en  = ~empty & (credit < 3'd2);

  // Decode capture/pop into one buffer action
  always_comb begin
    op = BUF_IDLE;
    case ({inflight, pop})
      2'b01:   op = BUF_POP;
      2'b10:   op = BUF_PUSH;
      2'b11:   op = BUF_SWAP;
      default: op = BUF_IDLE;
    endcase
  end

  // Read data arrives one cycle after each issued read
  always_ff @(posedge clk_B or posedge rst_B) begin
    if (rst_B) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
    end
  end

  // Two-entry output buffer, head is presented downstream
  always_ff @(posedge clk_B or posedge rst_B) begin
    if (rst_B) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case (op)
        BUF_PUSH: begin
          if (cnt == 2'd0) head <= rd_data;
          else             tail <= rd_data;
          cnt <= cnt + 2'd1;
        end
        BUF_POP: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        BUF_SWAP: begin
          if (cnt == 2'd2) begin
            head <= tail;
            tail <= rd_data;
          end else begin
            head <= rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
